// File: rtl/msrv32_pkg.sv
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared types and codes for the msrv32 data-memory access
//               controller: FSM state encoding, access size codes, AHB
//               response codes and a misalignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package msrv32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // Size code 2'b11 is treated as a word, so size[1] alone marks a word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lsb);
        logic r;
        r = 1'b0;
        if (size == SZ_HALF)
            r = lsb[0];
        else if (size[1])
            r = (lsb != 2'b00);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msrv32_store_lane_gen.sv
// ============================================================================
// Module      : msrv32_store_lane_gen
// Description : Combinational byte-lane mask and store-data replication.
//               Ports: size_i (access size), addr_lsb_i (address bits 1:0),
//                      rs2_i (store data), mask_o (byte enables),
//                      data_o (lane-replicated store data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_store_lane_gen
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lsb_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [3:0]      mask_o,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        mask_o = 4'b1111;
        data_o = rs2_i;
        case (size_i)
            SZ_BYTE: begin
                mask_o = 4'b0001 << addr_lsb_i;
                data_o = {(XLEN/8){rs2_i[7:0]}};
            end
            SZ_HALF: begin
                // A misaligned half drops addr[0] and lands on its half-word.
                mask_o = 4'b0011 << {addr_lsb_i[1], 1'b0};
                data_o = {(XLEN/16){rs2_i[15:0]}};
            end
            default: begin
                mask_o = 4'b1111;
                data_o = rs2_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/msrv32_dmem_access_ctrl.sv
// ============================================================================
// Module      : msrv32_dmem_access_ctrl
// Description : Load/store sequencer for the msrv32 AHB-style data bus.
//               Latches a request, issues one address phase, waits out the
//               data phase, captures read data and reports completion, bus
//               errors and timeouts. Stalls the pipeline while busy.
//               Ports: execute-stage request (load/store_req_in, iadder_in,
//                      load_size_in, rs2_in); bus side (dmaddr/dmdata/
//                      dmwr_req/dmrd_req/dmwr_mask out, hready/ahb_resp/
//                      dmdata in); load-unit side (lu_* out); status
//                      (lsu_stall_out, bus_err_out, timeout_out).
//               Optional: MSRV32_MISALIGN_TRAP_EN adds misaligned_out and
//                      traps misaligned half/word accesses without a bus
//                      cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_dmem_access_ctrl
    import msrv32_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            load_req_in,
    input  logic            store_req_in,
    input  logic [XLEN-1:0] iadder_in,
    input  logic [1:0]      load_size_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic [XLEN-1:0] ms_riscv32_mp_dmaddr_out,
    output logic [XLEN-1:0] ms_riscv32_mp_dmdata_out,
    output logic            ms_riscv32_mp_dmwr_req_out,
    output logic            ms_riscv32_mp_dmrd_req_out,
    output logic [3:0]      ms_riscv32_mp_dmwr_mask_out,
    input  logic            ms_riscv32_mp_hready_in,
    input  logic            ahb_resp_in,
    input  logic [XLEN-1:0] ms_riscv32_mp_dmdata_in,
    output logic [XLEN-1:0] lu_data_out,
    output logic [1:0]      lu_addr_1_to_0_out,
    output logic [1:0]      lu_size_out,
    output logic            lu_valid_out,
    output logic            lsu_stall_out,
    output logic            bus_err_out,
`ifdef MSRV32_MISALIGN_TRAP_EN
    output logic            misaligned_out,
`endif
    output logic            timeout_out
);

    // Counter value in the last ADDR/DATA cycle allowed before abort.
    localparam logic [TO_CNT_W-1:0] C_TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                is_store_q, is_store_d;
    logic [3:0]          mask_q, mask_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     lu_data_q, lu_data_d;
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                to_flag_q, to_flag_d;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
`endif

    logic                w_req;
    logic                w_req_store;
    logic [3:0]          w_lane_mask;
    logic [XLEN-1:0]     w_lane_data;

    assign w_req       = load_req_in | store_req_in;
    // A simultaneous load and store keeps the load.
    assign w_req_store = store_req_in & ~load_req_in;

    msrv32_store_lane_gen #(
        .XLEN (XLEN)
    ) u_lane_gen (
        .size_i     (load_size_in),
        .addr_lsb_i (iadder_in[1:0]),
        .rs2_i      (rs2_in),
        .mask_o     (w_lane_mask),
        .data_o     (w_lane_data)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            is_store_q <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            lu_data_q  <= '0;
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            is_store_q <= is_store_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            lu_data_q  <= lu_data_d;
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        is_store_d = is_store_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        lu_data_d  = lu_data_q;
        to_cnt_d   = to_cnt_q;
        to_flag_d  = to_flag_q;
`ifdef MSRV32_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    addr_d     = iadder_in;
                    size_d     = load_size_in;
                    is_store_d = w_req_store;
                    mask_d     = w_req_store ? w_lane_mask : 4'b0000;
                    wdata_d    = w_lane_data;
                    to_cnt_d   = '0;
                    to_flag_d  = 1'b0;
                    state_d    = ST_ADDR;
`ifdef MSRV32_MISALIGN_TRAP_EN
                    misalign_d = is_misaligned(load_size_in, iadder_in[1:0]);
                    if (misalign_d)
                        state_d = ST_ERR;
`endif
                end
            end
            ST_ADDR: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Moving to DATA is not a completion, so the timeout wins.
                if (to_cnt_q == C_TO_LAST) begin
                    state_d   = ST_ERR;
                    to_flag_d = 1'b1;
                end else if (ms_riscv32_mp_hready_in) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A response arriving in the final cycle still completes.
                if (ms_riscv32_mp_hready_in) begin
                    if (ahb_resp_in == RESP_OKAY) begin
                        if (!is_store_q)
                            lu_data_d = ms_riscv32_mp_dmdata_in;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (to_cnt_q == C_TO_LAST) begin
                    state_d   = ST_ERR;
                    to_flag_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ms_riscv32_mp_dmaddr_out    = {addr_q[XLEN-1:2], 2'b00};
    assign ms_riscv32_mp_dmdata_out    = wdata_q;
    assign ms_riscv32_mp_dmwr_mask_out = mask_q;
    assign ms_riscv32_mp_dmrd_req_out  = (state_q == ST_ADDR) & ~is_store_q;
    assign ms_riscv32_mp_dmwr_req_out  = (state_q == ST_ADDR) &  is_store_q;

    assign lu_data_out        = lu_data_q;
    assign lu_addr_1_to_0_out = addr_q[1:0];
    assign lu_size_out        = size_q;
    assign lu_valid_out       = (state_q == ST_DONE) & ~is_store_q;
    assign timeout_out        = (state_q == ST_ERR) & to_flag_q;

    // A request seen while reset is held is discarded, so it must not stall.
    assign lsu_stall_out = ((state_q == ST_IDLE) & w_req & ~ms_riscv32_mp_rst_in)
                         | (state_q == ST_ADDR)
                         | (state_q == ST_DATA);

`ifdef MSRV32_MISALIGN_TRAP_EN
    assign misaligned_out = (state_q == ST_ERR) &  misalign_q;
    assign bus_err_out    = (state_q == ST_ERR) & ~misalign_q;
`else
    assign bus_err_out    = (state_q == ST_ERR);
`endif

endmodule

`default_nettype wire

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_msrv32_dmem_access_ctrl
// Description : Directed self-checking bench for msrv32_dmem_access_ctrl.
//               Honours MSRV32_MISALIGN_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msrv32_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        load_req, store_req;
    logic [31:0] iadder, rs2;
    logic [1:0]  size;
    logic [31:0] dmaddr, dmdata_o;
    logic        wr_req, rd_req;
    logic [3:0]  mask;
    logic        hready, resp;
    logic [31:0] dmdata_i;
    logic [31:0] lu_data;
    logic [1:0]  lu_addr, lu_size;
    logic        lu_valid, stall, bus_err, timeout;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    msrv32_dmem_access_ctrl dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .load_req_in                 (load_req),
        .store_req_in                (store_req),
        .iadder_in                   (iadder),
        .load_size_in                (size),
        .rs2_in                      (rs2),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmdata_out    (dmdata_o),
        .ms_riscv32_mp_dmwr_req_out  (wr_req),
        .ms_riscv32_mp_dmrd_req_out  (rd_req),
        .ms_riscv32_mp_dmwr_mask_out (mask),
        .ms_riscv32_mp_hready_in     (hready),
        .ahb_resp_in                 (resp),
        .ms_riscv32_mp_dmdata_in     (dmdata_i),
        .lu_data_out                 (lu_data),
        .lu_addr_1_to_0_out          (lu_addr),
        .lu_size_out                 (lu_size),
        .lu_valid_out                (lu_valid),
        .lsu_stall_out               (stall),
        .bus_err_out                 (bus_err),
`ifdef MSRV32_MISALIGN_TRAP_EN
        .misaligned_out              (misaligned),
`endif
        .timeout_out                 (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle (checking the request-cycle stall),
    // then returns one cycle later with the controller in its next state.
    task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d);
        tick();
        load_req  = ld;
        store_req = st;
        iadder    = a;
        size      = sz;
        rs2       = d;
        #1;
        chk("req_stall", stall, 1);
        tick();
        load_req  = 1'b0;
        store_req = 1'b0;
    endtask

    logic [31:0] st_addr [4] = '{32'h2003, 32'h2002, 32'h2004, 32'h2001};
    logic [1:0]  st_size [4] = '{2'b00,    2'b01,    2'b10,    2'b00};
    logic [31:0] st_rs2  [4] = '{32'h000000A5, 32'h1234BEEF, 32'h01020304, 32'h0000005A};
    logic [31:0] st_eaddr[4] = '{32'h2000, 32'h2000, 32'h2004, 32'h2000};
    logic [3:0]  st_emask[4] = '{4'b1000,  4'b1100,  4'b1111,  4'b0010};
    logic [31:0] st_edata[4] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h01020304, 32'h5A5A5A5A};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_req = 1'b0; store_req = 1'b0;
        iadder = '0; rs2 = '0; size = '0;
        hready = 1'b1; resp = 1'b0; dmdata_i = '0;
        tick(); tick();
        chk("rst_rd", rd_req, 0);
        chk("rst_wr", wr_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_valid", lu_valid, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_to", timeout, 0);
        chk("rst_addr", dmaddr, 0);
        chk("rst_mask", mask, 0);
        chk("rst_ludata", lu_data, 0);
        rst = 1'b0;

        // Load word, zero-wait bus.
        do_req(1, 0, 32'h1000, 2'b10, 0);
        chk("lw_rd", rd_req, 1);
        chk("lw_wr", wr_req, 0);
        chk("lw_addr", dmaddr, 32'h1000);
        chk("lw_mask", mask, 0);
        chk("lw_stall_a", stall, 1);
        dmdata_i = 32'hDEADBEEF;
        tick();
        chk("lw_rd_data", rd_req, 0);
        chk("lw_stall_d", stall, 1);
        chk("lw_valid_d", lu_valid, 0);
        tick();
        chk("lw_valid", lu_valid, 1);
        chk("lw_data", lu_data, 32'hDEADBEEF);
        chk("lw_stall_done", stall, 0);
        tick();
        chk("lw_valid_off", lu_valid, 0);

        // Stores of each size and lane.
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1, st_addr[i], st_size[i], st_rs2[i]);
            chk("st_wr", wr_req, 1);
            chk("st_rd", rd_req, 0);
            chk("st_addr", dmaddr, st_eaddr[i]);
            chk("st_mask", mask, st_emask[i]);
            chk("st_data", dmdata_o, st_edata[i]);
            tick();
            chk("st_wr_off", wr_req, 0);
            tick();
            chk("st_valid", lu_valid, 0);
            chk("st_stall", stall, 0);
            chk("st_err", bus_err, 0);
            tick();
        end

        // Load half with five DATA wait states.
        do_req(1, 0, 32'h3002, 2'b01, 0);
        tick();
        hready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lh_wait_stall", stall, 1);
            chk("lh_wait_valid", lu_valid, 0);
            tick();
        end
        hready = 1'b1;
        dmdata_i = 32'hCAFEF00D;
        chk("lh_last_stall", stall, 1);
        tick();
        chk("lh_valid", lu_valid, 1);
        chk("lh_lsb", lu_addr, 2'b10);
        chk("lh_size", lu_size, 2'b01);
        chk("lh_data", lu_data, 32'hCAFEF00D);
        tick();

        // hready never rises: abort after 16 ADDR cycles.
        hready = 1'b0;
        do_req(1, 0, 32'h5000, 2'b10, 0);
        for (int i = 0; i < 16; i++) begin
            chk("to_stall", stall, 1);
            chk("to_err_early", bus_err, 0);
            tick();
        end
        chk("to_err", bus_err, 1);
        chk("to_flag", timeout, 1);
        chk("to_stall_off", stall, 0);
        chk("to_valid", lu_valid, 0);
        hready = 1'b1;
        tick();
        chk("to_err_off", bus_err, 0);
        chk("to_flag_off", timeout, 0);

        // ERROR response in DATA.
        do_req(1, 0, 32'h6000, 2'b10, 0);
        tick();
        resp = 1'b1;
        dmdata_i = 32'h12345678;
        tick();
        chk("er_err", bus_err, 1);
        chk("er_to", timeout, 0);
        chk("er_valid", lu_valid, 0);
        chk("er_data_kept", lu_data, 32'hCAFEF00D);
        resp = 1'b0;
        tick();
        chk("er_err_off", bus_err, 0);

        // Load and store together: load wins.
        do_req(1, 1, 32'h2003, 2'b00, 32'hA5);
        chk("both_rd", rd_req, 1);
        chk("both_wr", wr_req, 0);
        chk("both_mask", mask, 0);
        tick();
        dmdata_i = 32'h0BADF00D;
        tick();
        chk("both_valid", lu_valid, 1);
        chk("both_data", lu_data, 32'h0BADF00D);
        tick();

        // Reset in the middle of DATA.
        do_req(1, 0, 32'h7000, 2'b10, 0);
        tick();
        hready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_rd", rd_req, 0);
        chk("mr_stall", stall, 0);
        chk("mr_valid", lu_valid, 0);
        chk("mr_err", bus_err, 0);
        chk("mr_addr", dmaddr, 0);
        chk("mr_ludata", lu_data, 0);
        chk("mr_size", lu_size, 0);
        rst = 1'b0;
        hready = 1'b1;
        tick();
        chk("mr_valid2", lu_valid, 0);
        chk("mr_err2", bus_err, 0);

        // Misaligned word load at 0x4001.
        do_req(1, 0, 32'h4001, 2'b10, 0);
`ifdef MSRV32_MISALIGN_TRAP_EN
        chk("ma_flag", misaligned, 1);
        chk("ma_err", bus_err, 0);
        chk("ma_rd", rd_req, 0);
        chk("ma_stall", stall, 0);
        tick();
        chk("ma_flag_off", misaligned, 0);
        chk("ma_rd_off", rd_req, 0);
`else
        chk("ma_rd", rd_req, 1);
        chk("ma_addr", dmaddr, 32'h4000);
        chk("ma_lsb", lu_addr, 2'b01);
        dmdata_i = 32'h55AA55AA;
        tick();
        tick();
        chk("ma_valid", lu_valid, 1);
        chk("ma_data", lu_data, 32'h55AA55AA);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
